// File: rtl/vtile_rf_pkg.sv
// Shared constants and types for the vector-tile ping-pong operand register file.
package vtile_rf_pkg;

  localparam int unsigned VTILE_WIDTH  = 16;
  localparam int unsigned VTILE_LANES  = 4;
  localparam int unsigned VTILE_NUM_CH = 2;

  typedef logic [VTILE_WIDTH-1:0] lane_t;

  typedef enum logic {
    BUF0 = 1'b0,
    BUF1 = 1'b1
  } buf_sel_t;

  function automatic buf_sel_t buf_other(input buf_sel_t s);
    return (s == BUF0) ? BUF1 : BUF0;
  endfunction

endpackage

// File: rtl/vregfile_pp_rf_bank.sv
// One operand buffer: channel vectors, config slot and fill/seal flags.
// All strobes are pre-qualified by the parent; release and flush never overlap a seal.
module rf_bank
  import vtile_rf_pkg::*;
#(
  parameter int unsigned WIDTH  = VTILE_WIDTH,
  parameter int unsigned LANES  = VTILE_LANES,
  parameter int unsigned NUM_CH = VTILE_NUM_CH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CH-1:0]             wr_en,
  input  logic [NUM_CH*LANES*WIDTH-1:0] wr_data,
  input  logic                          cfg_wr,
  input  logic [WIDTH-1:0]              cfg_in,
  input  logic                          seal,
  input  logic [WIDTH-1:0]              fill_cfg,
  input  logic                          rel,
  input  logic                          flush,
  output logic [NUM_CH*LANES*WIDTH-1:0] data,
  output logic [WIDTH-1:0]              cfg,
  output logic [NUM_CH-1:0]             ch_full,
  output logic                          cfg_full,
  output logic                          sealed
);

  localparam int unsigned CH_W = LANES * WIDTH;

  // Element storage: each accepted channel overwrites its whole vector.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data <= '0;
    end else begin
      for (int c = 0; c < int'(NUM_CH); c++) begin
        if (wr_en[c]) begin
          data[c*CH_W +: CH_W] <= wr_data[c*CH_W +: CH_W];
        end
      end
    end
  end

  // Flags and cfg slot; an explicit cfg write beats the sticky fill at a seal edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cfg      <= '0;
      ch_full  <= '0;
      cfg_full <= 1'b0;
      sealed   <= 1'b0;
    end else if (rel) begin
      ch_full  <= '0;
      cfg_full <= 1'b0;
      sealed   <= 1'b0;
    end else if (flush) begin
      ch_full  <= '0;
      cfg_full <= 1'b0;
    end else begin
      ch_full <= ch_full | wr_en;
      if (cfg_wr) begin
        cfg      <= cfg_in;
        cfg_full <= 1'b1;
      end else if (seal && !cfg_full) begin
        cfg      <= fill_cfg;
        cfg_full <= 1'b1;
      end
      if (seal) begin
        sealed <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/vregfile_pp.sv
// Double-buffered operand register file: the network fills one bank while the FU
// drains the other; banks are presented strictly in seal order.
module vregfile_pp
  import vtile_rf_pkg::*;
#(
  parameter int unsigned WIDTH      = VTILE_WIDTH,
  parameter int unsigned LANES      = VTILE_LANES,
  parameter int unsigned NUM_CH     = VTILE_NUM_CH,
  parameter bit          CFG_STICKY = 1'b0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CH-1:0]             w_valid,
  output logic [NUM_CH-1:0]             w_ready,
  input  logic [NUM_CH*LANES*WIDTH-1:0] w_data,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [WIDTH-1:0]              cfg_data,
  input  logic                          flush,
  output logic                          r_valid,
  input  logic                          r_ready,
  output logic [NUM_CH*LANES*WIDTH-1:0] r_data,
  output logic [WIDTH-1:0]              r_cfg
);

  localparam int unsigned DW = NUM_CH * LANES * WIDTH;

  buf_sel_t          wr_sel;
  buf_sel_t          rd_sel;
  logic              cfg_seen;
  logic [WIDTH-1:0]  last_cfg;

  logic [DW-1:0]     bank_data     [2];
  logic [WIDTH-1:0]  bank_cfg      [2];
  logic [NUM_CH-1:0] bank_ch_full  [2];
  logic              bank_cfg_full [2];
  logic              bank_sealed   [2];

  logic              fill_sealed;
  logic [NUM_CH-1:0] fill_ch_full;
  logic              fill_cfg_full;
  logic [NUM_CH-1:0] w_acc;
  logic              cfg_acc;
  logic              seal_now;
  logic              rel_now;
  logic              flush_now;

  assign fill_sealed   = bank_sealed[wr_sel];
  assign fill_ch_full  = bank_ch_full[wr_sel];
  assign fill_cfg_full = bank_cfg_full[wr_sel];

  // Ready is forced low while reset is held so nothing is offered mid-reset.
  assign w_ready   = (reset && !fill_sealed) ? ~fill_ch_full : '0;
  assign cfg_ready = reset && !fill_sealed && !fill_cfg_full;

  // Handshakes landing during a flush are dropped.
  assign w_acc     = (w_valid & w_ready) & {NUM_CH{!flush}};
  assign cfg_acc   = cfg_valid && cfg_ready && !flush;

  assign seal_now  = !fill_sealed && (&fill_ch_full)
                     && (fill_cfg_full || (CFG_STICKY && cfg_seen)) && !flush;
  assign flush_now = flush && !fill_sealed;

  assign r_valid   = bank_sealed[rd_sel];
  assign rel_now   = r_valid && r_ready;
  assign r_data    = r_valid ? bank_data[rd_sel] : '0;
  assign r_cfg     = r_valid ? bank_cfg[rd_sel]  : '0;

  for (genvar i = 0; i < 2; i++) begin : g_bank
    logic fill_hit;
    logic read_hit;

    assign fill_hit = (wr_sel == buf_sel_t'(1'(i)));
    assign read_hit = (rd_sel == buf_sel_t'(1'(i)));

    rf_bank #(
      .WIDTH  (WIDTH),
      .LANES  (LANES),
      .NUM_CH (NUM_CH)
    ) u_bank (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (fill_hit ? w_acc : '0),
      .wr_data  (w_data),
      .cfg_wr   (fill_hit && cfg_acc),
      .cfg_in   (cfg_data),
      .seal     (fill_hit && seal_now),
      .fill_cfg (last_cfg),
      .rel      (read_hit && rel_now),
      .flush    (fill_hit && flush_now),
      .data     (bank_data[i]),
      .cfg      (bank_cfg[i]),
      .ch_full  (bank_ch_full[i]),
      .cfg_full (bank_cfg_full[i]),
      .sealed   (bank_sealed[i])
    );
  end

  // Pointers and sticky-config history.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_sel   <= BUF0;
      rd_sel   <= BUF0;
      cfg_seen <= 1'b0;
      last_cfg <= '0;
    end else begin
      if (seal_now) begin
        wr_sel <= buf_other(wr_sel);
      end
      if (rel_now) begin
        rd_sel <= buf_other(rd_sel);
      end
      if (cfg_acc) begin
        cfg_seen <= 1'b1;
        last_cfg <= cfg_data;
      end
    end
  end

endmodule
